// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, flag bit positions and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_EOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Replace N and Z, keep C and V as they were.
    function automatic logic [3:0] set_nz(input logic [3:0] flags, input logic n, input logic z);
        logic [3:0] f;
        f         = flags;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_next;

    assign addend   = b_q[0] ? a_q : '0;
    assign acc_next = acc_q + addend;

    // Product is presented combinationally so the caller can register it on the final step edge.
    assign done    = (cnt_q == CntW'(1));
    assign product = acc_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= CntLoad;
        end else if (cnt_q != '0) begin
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            acc_q <= acc_next;
            cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides, registered result and an NZCV flag register.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       ALUControl,
    input  logic             FlagWrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic             out_illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;
    logic             fw_q, fw_d;

    logic             accept;
    logic             op_mul;
    logic             op_illegal;
    logic             op_arith;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign in_ready    = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign out_valid   = (state_q == StDone);
    assign accept      = in_valid & in_ready;
    assign op_mul      = MUL_EN && (ALUControl == OP_MUL);
    assign op_illegal  = (ALUControl == OP_RSVD) || (!MUL_EN && (ALUControl == OP_MUL));
    assign op_arith    = (ALUControl == OP_ADD) || (ALUControl == OP_SUB);

    // SUB is A + ~B + 1, so op[0] doubles as invert-select and carry-in.
    assign addend = ALUControl[0] ? ~srcB : srcB;
    assign sum    = {1'b0, srcA} + {1'b0, addend} + {{WIDTH{1'b0}}, ALUControl[0]};
    assign alu_c  = sum[WIDTH];
    assign alu_v  = ~(srcA[WIDTH-1] ^ srcB[WIDTH-1] ^ ALUControl[0])
                  & (srcA[WIDTH-1] ^ sum[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
            OP_AND:         alu_res = srcA & srcB;
            OP_ORR:         alu_res = srcA | srcB;
            OP_MOV:         alu_res = srcB;
            OP_EOR:         alu_res = srcA ^ srcB;
            default:        alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        fw_d      = fw_q;
        mul_start = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    fw_d = FlagWrite;
                    if (op_mul) begin
                        state_d   = StBusy;
                        mul_start = 1'b1;
                        illegal_d = 1'b0;
                    end else begin
                        state_d   = StDone;
                        illegal_d = op_illegal;
                        result_d  = alu_res;
                        if (FlagWrite && !op_illegal) begin
                            flags_d = set_nz(flags_q, alu_res[WIDTH-1], alu_res == '0);
                            if (op_arith) begin
                                flags_d[FLAG_C] = alu_c;
                                flags_d[FLAG_V] = alu_v;
                            end
                        end
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (mul_done) begin
                    state_d  = StDone;
                    result_d = mul_product;
                    if (fw_q) begin
                        flags_d = set_nz(flags_q, mul_product[WIDTH-1], mul_product == '0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            fw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            fw_q      <= fw_d;
        end
    end

    if (MUL_EN) begin : g_mul
        alu_mul_iter #(
            .WIDTH(WIDTH)
        ) u_mul (
            .clk    (clk),
            .reset_n(reset_n),
            .start  (mul_start),
            .a      (srcA),
            .b      (srcB),
            .done   (mul_done),
            .product(mul_product)
        );
    end else begin : g_no_mul
        assign mul_done    = 1'b0;
        assign mul_product = '0;
    end

    assign ALUResult   = result_q;
    assign ALUFlags    = flags_q;
    assign out_illegal = illegal_q & out_valid;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: 32-bit with MUL, 8-bit with MUL, 8-bit without MUL.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        FlagWrite = 1'b0;
    logic [2:0]  ALUControl = 3'b000;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    int          dut_sel = 0;

    logic        iv32, iv8, iv8n;
    logic        ir32, ir8, ir8n;
    logic        v32, v8, v8n;
    logic        il32, il8, il8n;
    logic [31:0] r32;
    logic [7:0]  r8, r8n;
    logic [3:0]  f32, f8, f8n;

    logic        mon_valid, mon_in_ready, mon_ill;
    logic [31:0] mon_result;
    logic [3:0]  mon_flags;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   txn_id = 0;

    always #5 clk = ~clk;

    assign iv32 = in_valid && (dut_sel == 0);
    assign iv8  = in_valid && (dut_sel == 1);
    assign iv8n = in_valid && (dut_sel == 2);

    alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) u_d32 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
        .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .FlagWrite(FlagWrite),
        .out_valid(v32), .out_ready(out_ready), .ALUResult(r32), .ALUFlags(f32),
        .out_illegal(il32)
    );

    alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) u_d8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .srcA(srcA[7:0]), .srcB(srcB[7:0]), .ALUControl(ALUControl), .FlagWrite(FlagWrite),
        .out_valid(v8), .out_ready(out_ready), .ALUResult(r8), .ALUFlags(f8),
        .out_illegal(il8)
    );

    alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) u_d8n (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8n), .in_ready(ir8n),
        .srcA(srcA[7:0]), .srcB(srcB[7:0]), .ALUControl(ALUControl), .FlagWrite(FlagWrite),
        .out_valid(v8n), .out_ready(out_ready), .ALUResult(r8n), .ALUFlags(f8n),
        .out_illegal(il8n)
    );

    always_comb begin
        mon_valid    = v32;
        mon_in_ready = ir32;
        mon_ill      = il32;
        mon_result   = r32;
        mon_flags    = f32;
        if (dut_sel == 1) begin
            mon_valid    = v8;
            mon_in_ready = ir8;
            mon_ill      = il8;
            mon_result   = {24'h0, r8};
            mon_flags    = f8;
        end else if (dut_sel == 2) begin
            mon_valid    = v8n;
            mon_in_ready = ir8n;
            mon_ill      = il8n;
            mon_result   = {24'h0, r8n};
            mon_flags    = f8n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every completed result taken by the consumer must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && mon_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output",
                         mon_result);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("txn%0d_result", mon_e.id), mon_result, mon_e.res);
                check($sformatf("txn%0d_flags", mon_e.id), 32'(mon_flags), 32'(mon_e.flags));
                check($sformatf("txn%0d_illegal", mon_e.id), 32'(mon_ill), 32'(mon_e.ill));
            end
        end
    end

    // Present a bundle and return 1 time unit after the accepting edge, in_valid still high.
    task automatic send(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic fw, input bit expect_out,
                        input logic [31:0] res, input logic [3:0] fl, input logic ill);
        exp_t e;
        bit   got;
        got = 1'b0;
        if (expect_out) begin
            e.id    = txn_id;
            e.res   = res;
            e.flags = fl;
            e.ill   = ill;
            exp_q.push_back(e);
        end
        txn_id++;
        dut_sel    = sel;
        ALUControl = op;
        srcA       = a;
        srcB       = b;
        FlagWrite  = fw;
        in_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mon_in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    // After a MUL acceptance: count edges until out_valid, and require in_ready low meanwhile.
    task automatic wait_result(input string name, input int lat_exp);
        int k;
        bit busy_ok;
        k       = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (mon_valid) begin
                k = i;
                break;
            end
            if (mon_in_ready) busy_ok = 1'b0;
        end
        check({name, "_latency"}, 32'(k), 32'(lat_exp));
        check({name, "_busy_in_ready_low"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale;
        bool_drain: begin end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            dut_sel = s;
            #1;
            check($sformatf("rst%0d_result", s), mon_result, 32'h0);
            check($sformatf("rst%0d_flags", s), 32'(mon_flags), 32'h0);
            check($sformatf("rst%0d_valid", s), 32'(mon_valid), 32'h0);
            check($sformatf("rst%0d_illegal", s), 32'(mon_ill), 32'h0);
            check($sformatf("rst%0d_in_ready", s), 32'(mon_in_ready), 32'h1);
        end
        dut_sel = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit datapath, flags carried from op to op
        send(0, OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 32'h8000_0000, 4'b1001, 0);
        send(0, OP_SUB, 32'h5, 32'h5, 1, 1, 32'h0, 4'b0110, 0);
        send(0, OP_AND, 32'hF0, 32'h0F, 1, 1, 32'h0, 4'b0110, 0);
        send(0, OP_ORR, 32'hF0, 32'h0F, 0, 1, 32'hFF, 4'b0110, 0);
        send(0, OP_EOR, 32'hFF, 32'h0F, 1, 1, 32'hF0, 4'b0010, 0);
        send(0, OP_MOV, 32'h1234, 32'h8000_0000, 1, 1, 32'h8000_0000, 4'b1010, 0);
        send(0, OP_SUB, 32'h0, 32'h1, 1, 1, 32'hFFFF_FFFF, 4'b1000, 0);
        send(0, OP_SUB, 32'h8000_0000, 32'h1, 1, 1, 32'h7FFF_FFFF, 4'b0011, 0);
        send(0, OP_RSVD, 32'h1, 32'h1, 1, 1, 32'h0, 4'b0011, 1);
        send(0, OP_ADD, 32'h1, 32'h1, 0, 1, 32'h2, 4'b0011, 0);
        send(0, OP_ADD, 32'h2, 32'h2, 0, 1, 32'h4, 4'b0011, 0);
        send(0, OP_ADD, 32'h3, 32'h3, 0, 1, 32'h6, 4'b0011, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_result", i), mon_result, 32'h6);
            check($sformatf("hold%0d_in_ready", i), 32'(mon_in_ready), 32'h0);
            check($sformatf("hold%0d_valid", i), 32'(mon_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        send(0, OP_MUL, 32'hFFFF_FFFF, 32'h3, 1, 1, 32'hFFFF_FFFD, 4'b1011, 0);
        in_valid = 1'b0;
        wait_result("mul32", 32);
        @(posedge clk);
        #1;

        // 8-bit multiplier
        send(1, OP_MUL, 32'd13, 32'd11, 1, 1, 32'h8F, 4'b1000, 0);
        in_valid = 1'b0;
        wait_result("mul8_a", 8);
        @(posedge clk);
        #1;
        send(1, OP_MUL, 32'd16, 32'd16, 0, 1, 32'h0, 4'b1000, 0);
        in_valid = 1'b0;
        wait_result("mul8_b", 8);
        @(posedge clk);
        #1;

        // Reset in the third BUSY cycle abandons the op
        send(1, OP_MUL, 32'd13, 32'd11, 1, 0, 32'h0, 4'b0000, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_result", mon_result, 32'h0);
        check("midrst_flags", 32'(mon_flags), 32'h0);
        check("midrst_valid", 32'(mon_valid), 32'h0);
        check("midrst_illegal", 32'(mon_ill), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 32'(mon_in_ready), 32'h1);
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mon_valid) stale = 1'b1;
        end
        check("postrst_no_stale_valid", 32'(stale), 32'h0);
        @(posedge clk);
        #1;

        // MUL disabled: op 110 behaves as reserved
        send(2, OP_ADD, 32'h7F, 32'h1, 1, 1, 32'h80, 4'b1001, 0);
        send(2, OP_MUL, 32'h3, 32'h5, 1, 1, 32'h0, 4'b1001, 1);
        in_valid = 1'b0;

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the datapath ALU. Supports a 3-bit op field, a registered result, and an architectural NZCV flag register written only on S-bit ops.
- Adds an iterative shift-add multiplier.
- Sits between the decode/register-read stage and writeback. Uses valid/ready handshakes on both sides so a multi-cycle op can stall the pipe.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 4.
- MUL_EN, 1: 1 enables the MUL op; 0 makes op 3'b110 behave as reserved.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- srcA  in  WIDTH  operand A.
- srcB  in  WIDTH  operand B.
- ALUControl  in  3  op: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV (srcB), 101 EOR, 110 MUL, 111 reserved.
- FlagWrite  in  1  S-bit; flags are updated at completion only if this was 1 at acceptance.
- out_valid  out  1  ALUResult holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- ALUResult  out  WIDTH  registered result.
- ALUFlags  out  4  architectural flags {N,Z,C,V}; registered.
- out_illegal  out  1  valid with out_valid; result came from reserved op (or MUL with MUL_EN=0).

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - ALUResult, ALUFlags, out_valid and out_illegal all 0.
  - MUL counter and shift registers cleared.
  - Reset asserted mid-MUL abandons the op with no output.
- FSM states: IDLE, BUSY, DONE.
- Handshake and transitions:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - out_valid = (state==DONE).
  - Acceptance happens on an edge with in_valid & in_ready. ALUControl and FlagWrite are latched at acceptance.
  - Accepted non-MUL op: result and flags computed that cycle; state -> DONE at that edge (latency 1).
  - Accepted MUL op: state -> BUSY and counter loads WIDTH. Each BUSY edge processes one multiplier bit (LSB first) and decrements the counter. The edge where the counter goes 1->0 writes the result and flags; state -> DONE. out_valid rises WIDTH edges after the acceptance edge.
  - DONE & out_ready & ~in_valid -> IDLE.
  - DONE & out_ready & in_valid -> new op accepted back-to-back, giving one result per cycle for non-MUL ops.
  - DONE & ~out_ready: ALUResult, ALUFlags and out_illegal are held stable, and in_ready=0.
  - in_valid during BUSY is ignored (in_ready=0); the producer must hold its bundle.
- Arithmetic:
  - ADD/SUB: sum = srcA + (op[0] ? ~srcB : srcB) + op[0], computed WIDTH+1 bits wide.
  - C = sum[WIDTH]. For SUB this is the ARM "no borrow" convention.
  - V = ~(A[msb]^B[msb]^op[0]) & (A[msb]^sum[msb-1]).
- Logic ops, MOV, MUL:
  - MUL result = low WIDTH bits of A*B, unsigned and identical for signed.
  - N = result MSB; Z = (result==0); C and V keep their previous register values.
- Flag writes: ALUFlags changes only at the completion edge of an op latched with FlagWrite=1. FlagWrite=0 leaves ALUFlags untouched.
- Reserved op: ALUResult=0, out_illegal=1, flags never written regardless of FlagWrite, latency 1.

Decomposition:
- Package alu_pkg holds:
  - Op encoding localparams: OP_ADD..OP_RSVD.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state encoding.
- Sub-module alu_mul_iter, parametrised by WIDTH:
  - Holds the shift-add datapath and its own counter.
  - Interface: start, A, B -> done pulse, product.
- alu_mc holds the FSM, the combinational ADD/SUB/logic datapath, and the flag register.

Test Plan:
- WIDTH=32 ADD, FlagWrite=1, A=32'h7FFFFFFF, B=1 -> next cycle out_valid=1, ALUResult=32'h80000000, ALUFlags=4'b1001.
- SUB, FlagWrite=1, A=5, B=5 -> ALUResult=0, flags 4'b0110. Then AND, FlagWrite=1, A=32'hF0, B=32'h0F -> ALUResult=0, flags stay 4'b0110 (C,V preserved).
- MUL, WIDTH=8, A=8'd13, B=8'd11 -> in_ready=0 for the 8 BUSY cycles; out_valid rises 8 edges after acceptance; ALUResult=8'h8F; N=1, Z=0 written.
- Back-to-back ADDs (1+1, 2+2, 3+3) with out_ready held 1 -> results 2, 4, 6 on consecutive cycles. Then out_ready=0 for 3 cycles -> ALUResult=6 held, in_ready=0.
- ALUControl=3'b111 with FlagWrite=1 -> ALUResult=0, out_illegal=1, ALUFlags unchanged. With MUL_EN=0, op 110 gives the same response.
- reset_n pulled low on the 3rd BUSY cycle of a MUL -> outputs 0 immediately. After release, state is IDLE, in_ready=1, and no stale out_valid appears.
